// File: rtl/enemy_wave_ctrl_if.sv
// Signal bundle between game control (master) and enemy_wave_ctrl (slave).
// ENEMY_WAVE_SCORE_EN adds the 8-bit score output to the bundle.
interface enemy_wave_ctrl_if #(
    parameter int NUM_ENEMIES = 4
);
    logic                   game_start;
    logic                   abort;
    logic [NUM_ENEMIES-1:0] enemy_killed;
    logic [NUM_ENEMIES-1:0] enemy_death;
    logic [NUM_ENEMIES-1:0] enemy_start;
    logic [2:0]             alive_count;
    logic                   player_dead;
    logic                   level_clear;
    logic                   busy;
`ifdef ENEMY_WAVE_SCORE_EN
    logic [7:0]             score;
`endif

    modport slave (
`ifdef ENEMY_WAVE_SCORE_EN
        output score,
`endif
        input  game_start, abort, enemy_killed, enemy_death,
        output enemy_start, alive_count, player_dead, level_clear, busy
    );

    modport master (
`ifdef ENEMY_WAVE_SCORE_EN
        input  score,
`endif
        output game_start, abort, enemy_killed, enemy_death,
        input  enemy_start, alive_count, player_dead, level_clear, busy
    );
endinterface

// File: rtl/enemy_wave_ctrl.sv
// Staggers start pulses to a wave of enemies and reduces their flags to a dead/clear verdict.
// Optional feature macro: ENEMY_WAVE_SCORE_EN (adds a saturating kill score).
module enemy_wave_ctrl #(
    parameter int NUM_ENEMIES = 4,
    parameter int START_GAP   = 2000000
) (
    input logic             clk,
    input logic             reset,
    enemy_wave_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, STAGGER, RUN, DEAD, CLEAR} state_t;

    localparam logic [21:0] GAP_LOAD   = 22'(START_GAP - 1);
    localparam logic [1:0]  LAST_IDX   = 2'(NUM_ENEMIES - 1);
    localparam logic [2:0]  ALIVE_FULL = 3'(NUM_ENEMIES);

    state_t                 state_q;
    logic [21:0]            cnt_q;
    logic [1:0]             idx_q;
    logic                   lastSent_q;
    logic [NUM_ENEMIES-1:0] start_q;
    logic [2:0]             alive_q;
    logic                   dead_q;
    logic                   clear_q;
    logic                   busy_q;

    function automatic logic [2:0] countOnes(input logic [NUM_ENEMIES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

    logic hit;
    logic allKilled;
    assign hit       = (|bus.enemy_death) | bus.abort;
    assign allKilled = &bus.enemy_killed;

    // lastSent_q lets the final gap elapse after the last pulse, since idx stops at NUM_ENEMIES-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            lastSent_q <= 1'b0;
            start_q    <= '0;
            alive_q    <= ALIVE_FULL;
            dead_q     <= 1'b0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            start_q <= '0;
            busy_q  <= 1'b0;
            alive_q <= ALIVE_FULL - countOnes(bus.enemy_killed);
            dead_q  <= (state_q == DEAD);
            clear_q <= (state_q == CLEAR);
            case (state_q)
                IDLE: begin
                    alive_q <= ALIVE_FULL;
                    if (bus.game_start) begin
                        state_q    <= STAGGER;
                        cnt_q      <= '0;
                        idx_q      <= '0;
                        lastSent_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                STAGGER: begin
                    if (hit) begin
                        state_q <= DEAD;
                    end else if (cnt_q != '0) begin
                        cnt_q  <= cnt_q - 22'd1;
                        busy_q <= 1'b1;
                    end else if (lastSent_q) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_ENEMIES; i++)
                            if (idx_q == 2'(i)) start_q[i] <= 1'b1;
                        cnt_q  <= GAP_LOAD;
                        busy_q <= 1'b1;
                        if (idx_q == LAST_IDX) lastSent_q <= 1'b1;
                        else                   idx_q      <= idx_q + 2'd1;
                    end
                end
                RUN: begin
                    if (hit)            state_q <= DEAD;
                    else if (allKilled) state_q <= CLEAR;
                    else                busy_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.enemy_start = start_q;
    assign bus.alive_count = alive_q;
    assign bus.player_dead = dead_q;
    assign bus.level_clear = clear_q;
    assign bus.busy        = busy_q;

`ifdef ENEMY_WAVE_SCORE_EN
    logic [NUM_ENEMIES-1:0] killed_q;
    logic [7:0]             score_q;
    logic [8:0]             scoreSum;

    assign scoreSum = {1'b0, score_q} + {6'b0, countOnes(bus.enemy_killed & ~killed_q)};

    // Only rising killed edges score, and only while the wave is live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            killed_q <= '0;
            score_q  <= '0;
        end else begin
            killed_q <= bus.enemy_killed;
            if (state_q == STAGGER || state_q == RUN)
                score_q <= scoreSum[8] ? 8'hFF : scoreSum[7:0];
        end
    end

    assign bus.score = score_q;
`endif
endmodule
